hpdcache_mem_write_responder: RTL and testbench

Memory-side write responder for the HPDcache write channel. It accepts write request headers and write data beats from a cache-side initiator, such as the flush or write-buffer controllers, and drives a simple word-write port into a backing store. After a configurable latency it returns one write response per request, carrying the request ID. It is used as the slave end in subsystem benches and as the adapter in front of on-chip SRAM scratchpads.

---
 rtl/hpdcache_mem_write_responder.sv | 143 ++++++++++++++
 tb/tb_hpdcache_mem_write_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_mem_write_responder.sv
// HPDcache write-channel slave: header FIFO, word-write port, delayed write response.
// Define HPDCACHE_MEM_WR_RESP_LEN_CHECK_EN to check burst length against req_len_i.
module hpdcache_mem_write_responder #(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int IdWidth     = 4,
  parameter int LenWidth    = 8,
  parameter int HdrDepth    = 4,
  parameter int RespLatency = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [LenWidth-1:0]    req_len_i,
  input  logic [IdWidth-1:0]     req_id_i,
  input  logic                   data_valid_i,
  output logic                   data_ready_o,
  input  logic [DataWidth-1:0]   data_i,
  input  logic [DataWidth/8-1:0] data_be_i,
  input  logic                   data_last_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [IdWidth-1:0]     resp_id_o,
  output logic                   resp_error_o,
  output logic                   mem_we_o,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o
);
  localparam int BeatBytes = DataWidth / 8;
  localparam int ByteShift = $clog2(BeatBytes);
  localparam int PtrW      = $clog2(HdrDepth);
  localparam logic [3:0]  LatInit = 4'(RespLatency);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic [LenWidth-1:0]  len;
    logic [IdWidth-1:0]   id;
  } hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    WAIT,
    RESP
  } state_e;

  hdr_t                 fifo_q [HdrDepth];
  logic [PtrW:0]        wr_ptr_q;
  logic [PtrW:0]        rd_ptr_q;
  hdr_t                 head;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  state_e               state_q;
  logic [LenWidth:0]    beat_cnt_q;
  logic [3:0]           wait_q;
  logic                 beat_acc;
  logic                 beat_we;
  logic                 term_err;
  logic [AddrWidth-1:0] beat_off;

  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign empty = wr_ptr_q == rd_ptr_q;
  assign head  = fifo_q[rd_ptr_q[PtrW-1:0]];
  assign push  = req_valid_i && !full;

  assign beat_acc = (state_q == DATA) && data_valid_i;
  assign pop      = beat_acc && data_last_i;
  assign beat_off = AddrWidth'(beat_cnt_q) << ByteShift;

`ifdef HPDCACHE_MEM_WR_RESP_LEN_CHECK_EN
  assign beat_we  = beat_acc && (beat_cnt_q <= {1'b0, head.len});
  assign term_err = beat_cnt_q != {1'b0, head.len};
`else
  // len is stored but never checked in this build
  assign beat_we  = beat_acc;
  assign term_err = 1'b0 & (|head.len);
`endif

  assign req_ready_o  = !full;
  assign data_ready_o = state_q == DATA;
  assign resp_valid_o = state_q == RESP;
  assign mem_we_o     = beat_we;
  assign mem_addr_o   = beat_we ? head.addr + beat_off : '0;
  assign mem_wdata_o  = beat_we ? data_i : '0;
  assign mem_be_o     = beat_we ? data_be_i : '0;

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q[PtrW-1:0]] <= '{addr: req_addr_i,
                                      len:  req_len_i,
                                      id:   req_id_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      wait_q       <= '0;
      resp_id_o    <= '0;
      resp_error_o <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case (state_q)
        IDLE: if (!empty) state_q <= DATA;
        DATA: begin
          if (pop) begin
            resp_id_o    <= head.id;
            resp_error_o <= term_err;
            beat_cnt_q   <= '0;
            if (RespLatency > 0) begin
              wait_q  <= LatInit;
              state_q <= WAIT;
            end else begin
              state_q <= RESP;
            end
          end else if (beat_acc) begin
            // saturate so runaway bursts never wrap back into range
            beat_cnt_q <= beat_cnt_q +
                          {{LenWidth{1'b0}}, ~&beat_cnt_q};
          end
        end
        WAIT: begin
          wait_q <= wait_q - 4'd1;
          if (wait_q == 4'd1) state_q <= RESP;
        end
        RESP: if (resp_ready_i) state_q <= empty ? IDLE : DATA;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdcache_mem_write_responder.sv
// Randomized bench for hpdcache_mem_write_responder with a timeline-based reference model.
// Honors HPDCACHE_MEM_WR_RESP_LEN_CHECK_EN for error and write-count expectations.
module tb_hpdcache_mem_write_responder;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int LW = 8;
  localparam int HD = 4;
  localparam int RL = 2;
  localparam int BB = DW / 8;
`ifdef HPDCACHE_MEM_WR_RESP_LEN_CHECK_EN
  localparam bit LenChk = 1'b1;
`else
  localparam bit LenChk = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [LW-1:0] req_len_i = '0;
  logic [IW-1:0] req_id_i = '0;
  logic          data_valid_i = 1'b0;
  logic          data_ready_o;
  logic [DW-1:0] data_i = '0;
  logic [BB-1:0] data_be_i = '0;
  logic          data_last_i = 1'b0;
  logic          resp_valid_o;
  logic          resp_ready_i = 1'b0;
  logic [IW-1:0] resp_id_o;
  logic          resp_error_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BB-1:0] mem_be_o;

  always #5 clk = ~clk;

  hpdcache_mem_write_responder #(
    .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW),
    .LenWidth(LW), .HdrDepth(HD), .RespLatency(RL)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_id_i(req_id_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_i(data_i), .data_be_i(data_be_i), .data_last_i(data_last_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_id_o(resp_id_o), .resp_error_o(resp_error_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [IW-1:0] id;
    int            tgt;
    int            tp;
  } hdr_t;

  // model: header queue plus a timeline of when data opens and responses appear
  hdr_t          hq[$];
  int            m_beat = 0;
  int            m_phase = 0;
  int            m_done = -100;
  int            m_vat = 0;
  logic [IW-1:0] m_rid = '0;
  logic          m_rerr = 1'b0;

  int            cyc = 0;
  int            n_pass = 0;
  int            n_chk = 0;
  int            n_wr = 0;
  logic [IW-1:0] resp_log[$];
  logic          last_rerr = 1'b0;
  int            dv_pct = 0;
  int            rr_pct = 100;
  int            req_tgt = 0;

  bit            e_has, e_dr, e_acc, e_term, e_we, e_rv, e_rdy;
  int            e_open;
  logic [AW-1:0] e_addr;
  hdr_t          e_new;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    data_valid_i = ($urandom_range(0, 99) < dv_pct);
    data_i       = {$urandom, $urandom};
    data_be_i    = BB'($urandom);
    data_last_i  = (hq.size() > 0) && (m_beat == hq[0].tgt);
    resp_ready_i = ($urandom_range(0, 99) < rr_pct);
  end

  always @(negedge clk) begin
    if (rst_i) begin
      hq.delete();
      m_beat  = 0;
      m_phase = 0;
      m_done  = -100;
    end else begin
      e_has  = hq.size() > 0;
      e_rdy  = hq.size() < HD;
      e_open = 0;
      if (e_has) e_open = (m_done + 1 > hq[0].tp + 2) ? m_done + 1 : hq[0].tp + 2;
      e_dr   = (m_phase == 0) && e_has && (cyc >= e_open);
      e_acc  = e_dr && data_valid_i;
      e_term = e_acc && data_last_i;
      e_we   = e_acc;
      if (LenChk && e_acc) e_we = m_beat <= hq[0].len;
      e_addr = '0;
      if (e_we) e_addr = hq[0].addr + AW'(m_beat * BB);
      e_rv   = (m_phase == 1) && (cyc >= m_vat);
      chk("req_ready", req_ready_o, e_rdy);
      chk("data_ready", data_ready_o, e_dr);
      chk("mem_we", mem_we_o, e_we);
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_wdata", mem_wdata_o, e_we ? data_i : '0);
      chk("mem_be", mem_be_o, e_we ? data_be_i : '0);
      chk("resp_valid", resp_valid_o, e_rv);
      if (e_rv) begin
        chk("resp_id", resp_id_o, m_rid);
        chk("resp_error", resp_error_o, m_rerr);
      end
      if (mem_we_o) n_wr++;
      if (e_term) begin
        m_rid  = hq[0].id;
        m_rerr = LenChk && (m_beat != hq[0].len);
        void'(hq.pop_front());
        m_beat  = 0;
        m_phase = 1;
        m_vat   = cyc + 1 + RL;
      end else if (e_acc) begin
        m_beat++;
      end
      if (e_rv && resp_ready_i) begin
        m_phase = 0;
        m_done  = cyc;
        resp_log.push_back(resp_id_o);
        last_rerr = resp_error_o;
      end
      if (req_valid_i && e_rdy) begin
        e_new.addr = req_addr_i;
        e_new.len  = int'(req_len_i);
        e_new.id   = req_id_i;
        e_new.tgt  = req_tgt;
        e_new.tp   = cyc;
        hq.push_back(e_new);
      end
    end
  end

  task automatic push_hdr(logic [AW-1:0] a, int l, logic [IW-1:0] id, int tg);
    int w;
    w = 0;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_addr_i  = a;
    req_len_i   = LW'(l);
    req_id_i    = id;
    req_tgt     = tg;
    @(negedge clk);
    while (!req_ready_o && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle(int lim);
    int w;
    w = 0;
    while ((hq.size() > 0 || m_phase != 0) && w < lim) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= lim) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_neg(input bit use_we, output bit ok);
    int w;
    w = 0;
    ok = 1'b1;
    @(negedge clk);
    while ((use_we ? !mem_we_o : !resp_valid_o) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      chk(use_we ? "we_timeout" : "resp_timeout", 0, 1);
      ok = 1'b0;
    end
  endtask

  initial begin
    int d, w, n0;
    bit ok;
    logic [AW-1:0] a;
    int l, tg;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_data_ready", data_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_id", resp_id_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);

    dv_pct = 100;
    rr_pct = 100;
    push_hdr(32'h100, 0, 4'd3, 0);
    wait_neg(1'b1, ok);
    d = cyc;
    chk("t1_addr", mem_addr_o, 32'h100);
    wait_neg(1'b0, ok);
    chk("t1_latency", cyc - d, 3);
    chk("t1_id", resp_id_o, 3);
    chk("t1_err", resp_error_o, 0);
    wait_idle(100);

    push_hdr(32'h1000, 3, 4'd5, 3);
    wait_neg(1'b1, ok);
    for (int i = 0; i < 4; i++) begin
      chk("t2_we", mem_we_o, 1);
      chk("t2_addr", mem_addr_o, 32'h1000 + 32'(8 * i));
      if (i < 3) @(negedge clk);
    end
    wait_idle(100);

    dv_pct = 0;
    resp_log.delete();
    for (int i = 0; i < 4; i++) push_hdr(32'h2000 + 32'(i * 256), 0, IW'(i), 0);
    @(negedge clk);
    chk("t3_full", req_ready_o, 0);
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_addr_i  = 32'h2400;
    req_len_i   = '0;
    req_id_i    = 4'd4;
    req_tgt     = 0;
    n0 = n_wr;
    repeat (5) @(negedge clk);
    chk("t3_hold", req_ready_o, 0);
    dv_pct = 100;
    w = 0;
    while (!req_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("t3_after_last", (n_wr > n0) && (w < 100), 1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    wait_idle(200);
    chk("t3_nresp", resp_log.size(), 5);
    for (int i = 0; i < 4; i++)
      if (resp_log.size() > i) chk("t3_order", resp_log[i], IW'(i));

    rr_pct = 0;
    push_hdr(32'h3000, 1, 4'd7, 1);
    push_hdr(32'h3100, 1, 4'd8, 1);
    wait_neg(1'b0, ok);
    for (int i = 0; i < 10; i++) begin
      chk("t4_valid", resp_valid_o, 1);
      chk("t4_id", resp_id_o, 7);
      chk("t4_dready", data_ready_o, 0);
      @(negedge clk);
    end
    rr_pct = 100;
    w = 0;
    while (resp_valid_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t4_dready_after", data_ready_o, 1);
    wait_idle(200);

    n0 = n_wr;
    push_hdr(32'h4000, 3, 4'd2, 1);
    wait_idle(200);
    chk("t5_short_writes", n_wr - n0, 2);
    chk("t5_short_err", last_rerr, LenChk);
    n0 = n_wr;
    push_hdr(32'h4100, 1, 4'd6, 3);
    wait_idle(200);
    chk("t5_long_writes", n_wr - n0, LenChk ? 2 : 4);
    chk("t5_long_err", last_rerr, LenChk);

    push_hdr(32'h5000, 3, 4'd4, 3);
    w = 0;
    while (m_beat != 1 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("t6_req_ready", req_ready_o, 1);
    chk("t6_data_ready", data_ready_o, 0);
    chk("t6_resp_valid", resp_valid_o, 0);
    chk("t6_resp_id", resp_id_o, 0);
    chk("t6_mem_we", mem_we_o, 0);
    push_hdr(32'h6000, 1, 4'd9, 1);
    wait_neg(1'b0, ok);
    chk("t6_id", resp_id_o, 9);
    chk("t6_err", resp_error_o, 0);
    wait_idle(100);

    for (int k = 0; k < 200; k++) begin
      dv_pct = $urandom_range(30, 100);
      rr_pct = $urandom_range(20, 100);
      l  = $urandom_range(0, 3);
      tg = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4) : l;
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFF8);
      push_hdr(a, l, IW'($urandom), tg);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    #1;
    dv_pct = 100;
    rr_pct = 100;
    wait_idle(1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
